// File: rtl/apu_issue_pkg.sv
// Shared constants for the core-side APU issue path: default widths that
// match the APU core package and the bit positions of the upstream FP status flags.
package apu_issue_pkg;

  // Default interface widths
  localparam int unsigned NARGS_DEF           = 3;
  localparam int unsigned WOP_DEF             = 6;
  localparam int unsigned NDSFLAGS_DEF        = 15;
  localparam int unsigned NUSFLAGS_DEF        = 5;
  localparam int unsigned MAX_OUTSTANDING_DEF = 2;
  localparam int unsigned REGADDR_W_DEF       = 6;

  // Upstream status flag bit positions within apu_rflags / fflags
  localparam int unsigned FLAG_NV = 4;  // invalid operation
  localparam int unsigned FLAG_DZ = 3;  // divide by zero
  localparam int unsigned FLAG_OF = 2;  // overflow
  localparam int unsigned FLAG_UF = 1;  // underflow
  localparam int unsigned FLAG_NX = 0;  // inexact

  // Named view of the default-width status flags
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_status_t;

endpackage

// File: rtl/apu_tag_fifo.sv
// Synchronous FIFO holding destination register addresses of granted APU
// operations, in grant order. The head is readable combinationally so a pop
// can consume it in the same cycle the response arrives.
module apu_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Wrapping pointer increment that also works for non-power-of-2 depths
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO is fine when the head leaves in the same cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy next state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = ptr_inc(wptr_q);
      if (pop_ok)  rptr_d = ptr_inc(rptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Tag storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/apu_issue_ctrl.sv
// Core-side APU request initiator: holds one operation until granted, tracks
// granted operations in order through a tag FIFO, and turns responses into a
// registered register-file writeback plus sticky FP status flags.
module apu_issue_ctrl
  import apu_issue_pkg::*;
#(
  parameter int unsigned NARGS           = NARGS_DEF,
  parameter int unsigned WOP             = WOP_DEF,
  parameter int unsigned NDSFLAGS        = NDSFLAGS_DEF,
  parameter int unsigned NUSFLAGS        = NUSFLAGS_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned REGADDR_W       = REGADDR_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [NARGS*32-1:0]     issue_operands_i,
  input  logic [WOP-1:0]          issue_op_i,
  input  logic [NDSFLAGS-1:0]     issue_flags_i,
  input  logic [REGADDR_W-1:0]    issue_waddr_i,
  output logic                    apu_req_o,
  input  logic                    apu_gnt_i,
  output logic [NARGS*32-1:0]     apu_operands_o,
  output logic [WOP-1:0]          apu_op_o,
  output logic [NDSFLAGS-1:0]     apu_flags_o,
  input  logic                    apu_rvalid_i,
  input  logic [31:0]             apu_rdata_i,
  input  logic [NUSFLAGS-1:0]     apu_rflags_i,
  output logic                    wb_valid_o,
  output logic [REGADDR_W-1:0]    wb_waddr_o,
  output logic [31:0]             wb_data_o,
  output logic [NUSFLAGS-1:0]     fflags_o,
  input  logic                    fflags_clr_i,
  output logic                    busy_o,
  output logic                    proto_err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  // Hold register
  logic                 hold_valid_q, hold_valid_d;
  logic [NARGS*32-1:0]  operands_q;
  logic [WOP-1:0]       op_q;
  logic [NDSFLAGS-1:0]  flags_q;
  logic [REGADDR_W-1:0] waddr_q;

  // Writeback and status
  logic                 wb_valid_q, wb_valid_d;
  logic [REGADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic [NUSFLAGS-1:0]  fflags_q, fflags_d;
  logic                 proto_err_q, proto_err_d;

  // Handshake and tracking
  logic                 handshake, accept, push, pop, orphan_rsp;
  logic                 fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_cnt;
  logic [REGADDR_W-1:0] fifo_head;

  // Request and issue handshakes
  always_comb begin
    apu_req_o     = hold_valid_q && !fifo_full;
    handshake     = apu_req_o && apu_gnt_i;
    issue_ready_o = (!hold_valid_q || handshake) && !flush_i;
    accept        = issue_valid_i && issue_ready_o;
    // Anything the APU does in a flush cycle is forgotten
    push          = handshake && !flush_i;
    pop           = apu_rvalid_i && !flush_i && !fifo_empty;
    orphan_rsp    = apu_rvalid_i && !flush_i && fifo_empty;
  end

  apu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (REGADDR_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (waddr_q),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Hold-valid next state: a same-cycle accept refills the slot the grant vacates
  always_comb begin
    hold_valid_d = hold_valid_q;
    if (flush_i) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
    end else if (handshake) begin
      hold_valid_d = 1'b0;
    end
  end

  // Hold register; payload only loads on accept so it is stable while held
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      operands_q   <= '0;
      op_q         <= '0;
      flags_q      <= '0;
      waddr_q      <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      if (accept) begin
        operands_q <= issue_operands_i;
        op_q       <= issue_op_i;
        flags_q    <= issue_flags_i;
        waddr_q    <= issue_waddr_i;
      end
    end
  end

  // Writeback, sticky flags and protocol error next state
  always_comb begin
    wb_valid_d  = pop;
    wb_waddr_d  = wb_waddr_q;
    wb_data_d   = wb_data_q;
    fflags_d    = fflags_clr_i ? '0 : fflags_q;
    proto_err_d = proto_err_q || orphan_rsp;
    if (pop) begin
      wb_waddr_d = fifo_head;
      wb_data_d  = apu_rdata_i;
      fflags_d   = fflags_d | apu_rflags_i;
    end
  end

  // Writeback and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q  <= 1'b0;
      wb_waddr_q  <= '0;
      wb_data_q   <= '0;
      fflags_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_data_q   <= wb_data_d;
      fflags_q    <= fflags_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Output mapping
  always_comb begin
    apu_operands_o = operands_q;
    apu_op_o       = op_q;
    apu_flags_o    = flags_q;
    wb_valid_o     = wb_valid_q;
    wb_waddr_o     = wb_waddr_q;
    wb_data_o      = wb_data_q;
    fflags_o       = fflags_q;
    proto_err_o    = proto_err_q;
    busy_o         = hold_valid_q || (fifo_cnt != '0) || wb_valid_q;
  end

endmodule

// File: doc/apu_issue_ctrl.md
Name: apu_issue_ctrl

Overview:
- Core-side initiator for the APU request/response protocol: the master that drives apu_req/operands/op/flags and consumes apu_gnt/rvalid/rdata/rflags.
- Accepts operations from the core's EX stage through a valid/ready interface and holds each one in a one-entry request register until the APU grants it.
- Tracks in-flight operations in order. The response channel carries no ID, so a destination-address FIFO is used.
- Produces registered writeback for the register file plus sticky accumulated FP status flags (fflags).

Parameters:
- NARGS, 3, number of 32-bit operands
- WOP, 6, APU op field width
- NDSFLAGS, 15, downstream flag width (int_fmt, src_fmt, dst_fmt, rnd_mode)
- NUSFLAGS, 5, upstream status flag width (NV, DZ, OF, UF, NX)
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered operations (power of 2, ≥1)
- REGADDR_W, 6, writeback register address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill pending request and all in-flight tracking
- issue_valid_i  in  1  core offers an operation
- issue_ready_o  out  1  operation accepted when valid&ready
- issue_operands_i  in  NARGS*32  operands
- issue_op_i  in  WOP  operation {vec_op, op_mod, op}
- issue_flags_i  in  NDSFLAGS  formats and rounding mode
- issue_waddr_i  in  REGADDR_W  destination register
- apu_req_o  out  1  request to APU
- apu_gnt_i  in  1  APU accepted request
- apu_operands_o  out  NARGS*32  held operands
- apu_op_o  out  WOP  held op
- apu_flags_o  out  NDSFLAGS  held flags
- apu_rvalid_i  in  1  result valid (no backpressure)
- apu_rdata_i  in  32  result
- apu_rflags_i  in  NUSFLAGS  status
- wb_valid_o  out  1  writeback strobe
- wb_waddr_o  out  REGADDR_W  writeback address
- wb_data_o  out  32  writeback data
- fflags_o  out  NUSFLAGS  sticky OR of status flags
- fflags_clr_i  in  1  clear fflags (CSR write)
- busy_o  out  1  request held or any op outstanding
- proto_err_o  out  1  sticky: rvalid received with nothing outstanding

Behaviour:
- Reset values: apu_req_o=0; wb_valid_o=0; wb_waddr_o, wb_data_o, fflags_o, apu_* payload=0; busy_o=0; proto_err_o=0; outstanding count=0; FIFO empty.
- Hold register: hold_valid is set on issue accept. apu_req_o = hold_valid && (cnt < MAX_OUTSTANDING). Payload is stable while hold_valid.
- Grant: handshake = apu_req_o && apu_gnt_i. It pushes the held waddr into the FIFO, increments cnt, and clears hold_valid unless a new issue is accepted in the same cycle.
- issue_ready_o = !hold_valid || handshake, and is 0 during flush_i. This allows back-to-back issue at one op per cycle when the APU grants every cycle.
- Response: on apu_rvalid_i, pop the FIFO head and decrement cnt. Next cycle: wb_valid_o=1, wb_waddr_o=head, wb_data_o=apu_rdata_i. wb_valid_o is a 1-cycle pulse; latency from rvalid to wb is 1 cycle.
- Simultaneous grant and rvalid: push and pop both happen, cnt is unchanged. Pop reads the old head, which is correct even when the FIFO is full.
- Full: at cnt==MAX_OUTSTANDING, apu_req_o drops and hold_valid is kept. Same-cycle rvalid does not re-enable req until the next cycle.
- rvalid with cnt==0 and no flush: set proto_err_o, suppress wb, leave cnt at 0.
- fflags: on the cycle wb_valid_o is set, fflags_o |= apu_rflags_i, using the registered value. If fflags_clr_i arrives in the same cycle, fflags_o = new flags only. A clear alone sets fflags_o=0.
- flush_i: clears hold_valid, FIFO pointers, and cnt. Any rvalid in the flush cycle is discarded (no wb, no flag update, no proto_err). An issue offered in the flush cycle is not accepted. apu_req_o is 0 the cycle after flush.
- busy_o = hold_valid || cnt != 0 || wb_valid_o.

Decomposition:
- Shared package apu_issue_pkg: status flag bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0) and default width constants matching the APU core package.
- Sub-module apu_tag_fifo: synchronous FIFO of depth MAX_OUTSTANDING, width REGADDR_W, with push, pop, flush, full, empty and count outputs.

Test Plan:
- Single op: issue waddr=5; gnt at cycle 2; rvalid at cycle 5 with rdata=0x3F800000, rflags=0x01 -> wb at cycle 6 with addr 5 and data 0x3F800000; fflags_o=0x01; busy_o=0 afterwards.
- Back-to-back: gnt held at 1, issue waddr 1,2,3 on consecutive cycles, rvalid delayed 3 cycles -> third op stalls (req=0) until first rvalid; wb order is 1,2,3.
- Grant stall: gnt=0 for 4 cycles -> apu_req_o stays 1 with stable payload; issue_ready_o=0 while a second op waits.
- Flush: 2 ops outstanding, flush_i coincident with rvalid -> no wb; cnt=0; a later lone rvalid sets proto_err_o=1.
- Flags: wb with rflags 0x04 then 0x10 -> fflags_o=0x14; clr simultaneous with a wb carrying 0x02 -> fflags_o=0x02.
- Reset mid-operation: assert rst_ni low while hold_valid=1 and cnt=2 -> all outputs return to reset values immediately (asynchronously).
